// File: rtl/cla_pkg.sv
// Shared definitions for the CLA issue/retire controller.
//   CLA_W    adder datapath width
//   CLA_LAT  adder latency, issue edge to capture edge
//   RES_*    bit offsets of the fields in a result-FIFO entry:
//            {tag, zero, ovf, cout, sum} from MSB to LSB
package cla_pkg;

  localparam int CLA_W   = 16;
  localparam int CLA_LAT = 3;

  localparam int RES_SUM_LSB  = 0;
  localparam int RES_COUT_BIT = CLA_W;
  localparam int RES_OVF_BIT  = CLA_W + 1;
  localparam int RES_ZERO_BIT = CLA_W + 2;
  localparam int RES_TAG_LSB  = CLA_W + 3;

  function automatic int res_entry_w(input int tagw);
    return RES_TAG_LSB + tagw;
  endfunction

endpackage

// File: rtl/cla_result_fifo.sv
// Result FIFO, DEPTH entries of W bits.
//   clk, rst_n  clock, async active-low reset (clears pointers, count and storage)
//   push        write push_data (dropped when full)
//   pop         advance the head (ignored when empty)
//   head        entry at the read pointer
//   count       number of valid entries
//   full        count == DEPTH
module cla_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  output logic [W-1:0]    head,
  output logic [CNTW-1:0] count,
  output logic            full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cla_issue_ctrl.sv
// Issue/retire controller around the 3-stage pipelined 16-bit CLA add/sub unit.
//   req_*   tagged add/sub requests (valid/ready); req_ready depends on req_sub
//   add_*   adder interface: add_in1/add_as registered, add_in2 = req_b live,
//           add_out/add_cout captured LAT edges after issue
//   res_*   in-order results (valid/ready) with signed-overflow and zero flags
//   busy    ops in flight or results waiting
module cla_issue_ctrl import cla_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4,
  parameter int LAT   = CLA_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CLA_W-1:0] req_a,
  input  logic [CLA_W-1:0] req_b,
  input  logic             req_sub,
  input  logic [TAGW-1:0]  req_tag,
  output logic [CLA_W-1:0] add_in1,
  output logic [CLA_W-1:0] add_in2,
  output logic             add_as,
  input  logic [CLA_W-1:0] add_out,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CLA_W-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_zero,
  output logic [TAGW-1:0]  res_tag,
  output logic             busy
);

  localparam int EW   = res_entry_w(TAGW);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int OCCW = $clog2(DEPTH + LAT + 1);

  logic            as_q, iss_d1;
  logic            issue, switch_as, credit_ok;
  logic [LAT-1:0]  pv, psa, psb;
  logic [TAGW-1:0] ptag [LAT];
  logic [CNTW-1:0] fifo_count;
  logic            fifo_full;
  logic [OCCW-1:0] occ;
  logic            capture, cap_ovf, cap_zero;
  logic [EW-1:0]   cap_entry, head;

  // Occupancy = results waiting + ops still in the adder. Credits are only
  // returned by registered state, so a pop never frees a slot the same cycle.
  always_comb begin
    occ = OCCW'(fifo_count);
    for (int i = 0; i < LAT; i++) occ = occ + OCCW'(pv[i]);
  end

  assign credit_ok = occ < OCCW'(DEPTH);
  assign req_ready = credit_ok && (req_sub == as_q);
  assign issue     = req_valid && req_ready;
  // Never flip 'as' right after an issue: that op still uses it during its first stage.
  assign switch_as = req_valid && (req_sub != as_q) && !iss_d1;

  assign add_in2 = req_b;
  assign add_as  = as_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_q    <= 1'b0;
      iss_d1  <= 1'b0;
      add_in1 <= '0;
      pv      <= '0;
      psa     <= '0;
      psb     <= '0;
      for (int i = 0; i < LAT; i++) ptag[i] <= '0;
    end else begin
      iss_d1 <= issue;
      if (issue)     add_in1 <= req_a;
      if (switch_as) as_q    <= req_sub;
      // Index 0 is the op issued on this edge; index LAT-1 is captured next.
      pv      <= {pv[LAT-2:0], issue};
      psa     <= {psa[LAT-2:0], req_a[CLA_W-1]};
      psb     <= {psb[LAT-2:0], req_b[CLA_W-1] ^ req_sub};
      ptag[0] <= req_tag;
      for (int i = 1; i < LAT; i++) ptag[i] <= ptag[i-1];
    end
  end

  // Operand signs travel with the op; overflow when like-signed operands
  // (B sign effectively inverted for subtract) produce an opposite-sign sum.
  assign capture  = pv[LAT-1];
  assign cap_ovf  = (psa[LAT-1] == psb[LAT-1]) && (add_out[CLA_W-1] != psa[LAT-1]);
  assign cap_zero = (add_out == '0);

  always_comb begin
    cap_entry = '0;
    cap_entry[RES_SUM_LSB +: CLA_W]   = add_out;
    cap_entry[RES_COUT_BIT]           = add_cout;
    cap_entry[RES_OVF_BIT]            = cap_ovf;
    cap_entry[RES_ZERO_BIT]           = cap_zero;
    cap_entry[RES_TAG_LSB +: TAGW]    = ptag[LAT-1];
  end

  cla_result_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (cap_entry),
    .pop       (res_ready),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  a_no_full_capture: assert property (@(posedge clk) disable iff (!rst_n) capture |-> !fifo_full);

  assign res_valid = (fifo_count != '0);
  assign res_sum   = head[RES_SUM_LSB +: CLA_W];
  assign res_cout  = head[RES_COUT_BIT];
  assign res_ovf   = head[RES_OVF_BIT];
  assign res_zero  = head[RES_ZERO_BIT];
  assign res_tag   = head[RES_TAG_LSB +: TAGW];
  assign busy      = (occ != '0);

endmodule

// File: tb/tb_cla_issue_ctrl.sv
module tb_cla_issue_ctrl;

  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_sub;
  logic [15:0]     req_a, req_b;
  logic [TAGW-1:0] req_tag;
  logic [15:0]     add_in1, add_in2, add_out;
  logic            add_as, add_cout;
  logic            res_valid, res_ready, res_cout, res_ovf, res_zero, busy;
  logic [15:0]     res_sum;
  logic [TAGW-1:0] res_tag;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            zero;
    logic            ovf;
    logic            cout;
    logic [15:0]     sum;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  always #5 clk = ~clk;

  cla_issue_ctrl #(.DEPTH(4), .TAGW(TAGW), .LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .req_tag(req_tag),
    .add_in1(add_in1), .add_in2(add_in2), .add_as(add_as),
    .add_out(add_out), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero), .res_tag(res_tag),
    .busy(busy)
  );

  // Adder emulation honouring the port contract: in2/as sampled at the issue
  // edge, in1 and as used live in the following cycle (an 'as' change there
  // corrupts the result), sum presented for capture at issue+3.
  logic [15:0] s1_in2;
  logic        s1_as;
  logic [16:0] s2_res, s3_res;
  always @(posedge clk) begin
    s1_in2 <= add_in2;
    s1_as  <= add_as;
    if (add_as != s1_as) s2_res <= 17'h15A5A;
    else if (add_as)     s2_res <= {1'b0, add_in1} + {1'b0, ~s1_in2} + 17'd1;
    else                 s2_res <= {1'b0, add_in1} + {1'b0, s1_in2};
    s3_res <= s2_res;
  end
  assign add_out  = s3_res[15:0];
  assign add_cout = s3_res[16];

  // Reference: plain integer arithmetic on the request.
  function automatic res_t ref_result(input logic [15:0] a, input logic [15:0] b,
                                      input logic sub, input logic [TAGW-1:0] tag);
    res_t r;
    int unsigned ua, ub;
    int sa, sb, sr;
    ua = a; ub = b;
    sa = int'($signed(a)); sb = int'($signed(b));
    if (sub) begin
      r.sum  = 16'(ua - ub);
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      r.sum  = 16'(ua + ub);
      r.cout = ((ua + ub) > 65535);
      sr     = sa + sb;
    end
    r.ovf  = (sr > 32767) || (sr < -32768);
    r.zero = (r.sum == 16'h0);
    r.tag  = tag;
    return r;
  endfunction

  // Handshake monitor: inputs change just after posedge, so values seen at
  // negedge are the ones the next posedge acts on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) exp_q.push_back(ref_result(req_a, req_b, req_sub, req_tag));
      if (res_valid && res_ready) obs_q.push_back({res_tag, res_zero, res_ovf, res_cout, res_sum});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; req_tag = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Call just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic [TAGW-1:0] tag, output int stalls);
    req_valid = 1'b1; req_a = a; req_b = b; req_sub = sub; req_tag = tag;
    stalls = 0;
    @(negedge clk);
    while (!req_ready && stalls < 60) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (add_as !== 1'b0) $display("FAIL reset_add_as: got %b want 0", add_as); else n_pass++;
    n_checks++; if ({res_sum, res_tag} !== '0) $display("FAIL reset_res_fields: got %h want 0", {res_sum, res_tag}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    int st;
    logic [3:0] vseen;
    send(16'h7FFF, 16'h0001, 1'b0, 4'd5, st);
    n_checks++; if (st !== 0) $display("FAIL add_stalls: got %0d want 0", st); else n_pass++;
    n_checks++; if (add_in1 !== 16'h7FFF) $display("FAIL add_in1: got %h want 7fff", add_in1); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vseen[k] = res_valid;
    end
    n_checks++; if (vseen !== 4'b1000) $display("FAIL add_latency: got valid pattern %b want 1000", vseen); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL add_busy: got %b want 1", busy); else n_pass++;
    n_checks++;
    if ({res_sum, res_cout, res_ovf, res_zero, res_tag} !== {16'h8000, 1'b0, 1'b1, 1'b0, 4'd5})
      $display("FAIL add_ovf_result: got sum=%h c=%b o=%b z=%b t=%0d want sum=8000 c=0 o=1 z=0 t=5",
               res_sum, res_cout, res_ovf, res_zero, res_tag);
    else n_pass++;
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL add_busy_after_pop: got %b want 0", busy); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_sub_switch();
    int st;
    send(16'h0005, 16'h0005, 1'b1, 4'd9, st);
    n_checks++; if (st !== 1) $display("FAIL sub_switch_stalls: got %0d want 1", st); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({res_valid, res_sum, res_cout, res_ovf, res_zero, res_tag} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd9})
      $display("FAIL sub_zero_result: got v=%b sum=%h c=%b o=%b z=%b t=%0d want v=1 sum=0000 c=1 o=0 z=1 t=9",
               res_valid, res_sum, res_cout, res_ovf, res_zero, res_tag);
    else n_pass++;
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int st1, st2, st3;
    logic [15:0] want_sum [3];
    want_sum[0] = 16'd7; want_sum[1] = 16'd7; want_sum[2] = 16'd2;
    apply_reset();
    res_ready = 1'b1;
    send(16'd3, 16'd4, 1'b0, 4'd1, st1);
    send(16'd9, 16'd2, 1'b1, 4'd2, st2);
    send(16'd1, 16'd1, 1'b0, 4'd3, st3);
    n_checks++; if ({st1, st2, st3} !== {32'd0, 32'd2, 32'd2}) $display("FAIL b2b_bubbles: got %0d,%0d,%0d want 0,2,2", st1, st2, st3); else n_pass++;
    repeat (8) @(posedge clk); #1;
    n_checks++; if (obs_q.size() != 3) $display("FAIL b2b_count: got %0d want 3", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      n_checks++;
      if (obs_q[i].sum !== want_sum[i] || obs_q[i].tag !== TAGW'(i + 1))
        $display("FAIL b2b_sum[%0d]: got sum=%0d tag=%0d want sum=%0d tag=%0d", i, obs_q[i].sum, obs_q[i].tag, want_sum[i], i + 1);
      else n_pass++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int st;
    int ready_seen;
    logic [15:0] a [6];
    logic [15:0] b [6];
    logic [15:0] head0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
    for (int i = 0; i < 4; i++) begin
      send(a[i], b[i], 1'b0, TAGW'(i), st);
      n_checks++; if (st !== 0) $display("FAIL bp_accept[%0d]: stalls got %0d want 0", i, st); else n_pass++;
    end
    req_valid = 1'b1; req_a = a[4]; req_b = b[4]; req_sub = 1'b0; req_tag = TAGW'(4);
    ready_seen = 0;
    @(negedge clk); head0 = res_sum;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready) ready_seen++;
    end
    n_checks++; if (ready_seen !== 0) $display("FAIL bp_ready_held: got %0d ready cycles want 0", ready_seen); else n_pass++;
    n_checks++; if (exp_q.size() != 4) $display("FAIL bp_accepted: got %0d want 4", exp_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL bp_no_pop: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (res_valid !== 1'b1 || res_sum !== head0) $display("FAIL bp_head_stable: got v=%b sum=%h want v=1 sum=%h", res_valid, res_sum, head0); else n_pass++;
    n_checks++; if (res_sum !== a[0] + b[0]) $display("FAIL bp_head_value: got %h want %h", res_sum, a[0] + b[0]); else n_pass++;
    @(posedge clk); #1 res_ready = 1'b1;
    send(a[4], b[4], 1'b0, TAGW'(4), st);
    send(a[5], b[5], 1'b0, TAGW'(5), st);
    repeat (12) @(posedge clk); #1;
    n_checks++; if (obs_q.size() != 6 || exp_q.size() != 6) $display("FAIL bp_total: got %0d results %0d accepted want 6", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_res[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_midop();
    int st;
    int vseen;
    apply_reset();
    res_ready = 1'b1;
    send(16'd100, 16'd23, 1'b0, 4'd7, st);
    send(16'd200, 16'd45, 1'b0, 4'd8, st);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", req_ready); else n_pass++;
    vseen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) vseen++;
    end
    n_checks++; if (vseen !== 0) $display("FAIL midrst_no_result: got %0d valid cycles want 0", vseen); else n_pass++;
    @(posedge clk); #1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    bit done;
    int max_st;
    logic [15:0] corner [5];
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF;
    apply_reset();
    done = 1'b0;
    max_st = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [15:0] a, b;
          int st;
          a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
          b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
          send(a, b, 1'($urandom_range(0, 1)), TAGW'(i), st);
          if (st > max_st) max_st = st;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    n_checks++; if (max_st >= 60) $display("FAIL rnd_timeout: got stall count %0d want below 60", max_st); else n_pass++;
    n_checks++; if (obs_q.size() != 40 || exp_q.size() != 40) $display("FAIL rnd_count: got %0d results %0d accepted want 40", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rnd_res[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rnd_idle: got busy=%b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_switch();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
